downcounter: RTL and testbench
==============================

# downcounter

Loadable, saturating down-counter with a valid/ready load interface: the countdown counterpart of the free-running saturating up-counter. It accepts a start value, decrements while enabled, and pulses `done` on reaching zero. It provides timeouts, back-off intervals and credit-expiry timers inside the load balancer. An optional auto-reload mode restarts the countdown from the last loaded value.

## Interface
- `COUNT_BITS`, default 3: counter width; the maximum load value is 2**COUNT_BITS-1.

- `clk`  in  1  clock; all state changes on the rising edge.
- `resetn`  in  1  reset, asynchronous, active-low.
- `enable`  in  1  count enable; low pauses the countdown and holds `count`.
- `abort`  in  1  synchronous cancel; returns the block to IDLE.
- `load_valid`  in  1  start-value offer.
- `load_value`  in  COUNT_BITS  start value, sampled on handshake.
- `load_ready`  out  1  block can accept a start value.
- `count`  out  COUNT_BITS  current count, registered.
- `busy`  out  1  high in RUN or DONE.
- `done`  out  1  one-cycle pulse per expiry.
- `min_tick`  out  1  combinational flag, high when `count == 0`.

## Operation
- States are IDLE, RUN and DONE, in a registered FSM.
- Handshake:
  - A load is accepted on any edge where `load_valid && load_ready`.
  - `load_ready = (state == IDLE) && !abort`.
  - `load_value` may change freely while `load_valid` is low.
- **IDLE**:
  - `count` is 0.
  - On an accepted load with value N>0: `count <= N`, go to RUN.
  - On an accepted load with value N=0: go to DONE.
- **RUN**:
  - With `enable` high: `count <= count - 1`. When `count == 1`, the count steps to 0 and the FSM goes to DONE.
  - With `enable` low: `count` and the state hold.
  - `count` never wraps below 0.
- **DONE**:
  - Lasts exactly one cycle; `done` is high for that cycle. `enable` does not stretch it.
  - Next state is IDLE, unless auto-reload applies (see Configuration).
- **Abort**:
  - Priority is reset > abort > everything else.
  - `abort` high at an edge: state becomes IDLE, `count` becomes 0, and any pending load is not accepted.
  - If the block is in DONE during the abort cycle, `done` still shows for that cycle. No `done` is produced afterwards.
- **Outputs**:
  - `done = (state == DONE)`.
  - `busy = (state != IDLE)`.
  - `min_tick = (count == 0)`. It is high in IDLE and DONE and in no RUN cycle.

## Timing
- Reset values: state IDLE, `count` 0, `done` 0, `busy` 0, `load_ready` 1 (when `abort` is low), `min_tick` 1.
- Reset asserted mid-count clears everything immediately, with no edge needed. No `done` is emitted.
- Latency, with `enable` held high and the handshake at edge 0:
  - After edge 1, `count = N` and the FSM is in RUN; for N=0 the FSM is already in DONE.
  - After edge k, `count = N-k+1`.
  - `done` is high in the cycle after edge N+1.
- Total from handshake to `done` is N+1 cycles, plus one cycle for every cycle `enable` is low while in RUN.
- Back-to-back loads: without auto-reload, a new load is accepted at the earliest two edges after `done` was sampled high.

## Configuration
- **With `DOWNCOUNTER_AUTORELOAD_EN` defined**:
  - A COUNT_BITS reload register captures `load_value` on each accepted load.
  - DONE → RUN with `count <= reload` when the reload value is non-zero.
  - DONE → DONE when the reload value is 0, so `done` stays high continuously.
  - The only exit from auto-reload is `abort` or reset.
  - `load_ready` stays low throughout.
  - A period of N yields a `done` pulse every N+1 cycles.
- **Without the macro**: the reload register is not instantiated, and DONE always goes to IDLE.

## Test plan
- **Basic countdown**: COUNT_BITS=3, load 5 with `enable`=1.
  - `count` reads 5,4,3,2,1,0 on successive cycles.
  - `done` is high exactly once, 6 cycles after the handshake.
  - `busy` falls the cycle after `done`.
- **Zero load**: load 0.
  - `done` is high in the first cycle after the handshake.
  - `count` stays 0 and `min_tick` stays 1 throughout.
- **Pause**: load 7 and drop `enable` for 3 cycles while `count` is 4.
  - `count` holds 4.
  - `done` arrives at 8+3=11 cycles after the handshake.
- **Abort collisions**:
  - `abort` together with `load_valid` in IDLE: `load_ready` is 0, no load is taken, `count` stays 0.
  - `abort` in RUN at `count` 3: the next cycle shows IDLE with `count` 0, and `done` never fires.
- **Async reset**: assert `resetn`=0 between clock edges at `count` 6. `count`, `busy` and `done` go to 0 immediately, without a clock edge.
- **`DOWNCOUNTER_AUTORELOAD_EN`**:
  - Load 2: `done` pulses every 3 cycles for 4 periods and `load_ready` stays 0.
  - `abort` then ends the sequence, and `load_ready` returns to 1.

Source files
------------

// File: rtl/downcounter.sv
// Loadable saturating down-counter with valid/ready start-value interface and one-cycle done pulse.
// Optional auto-reload restart from the last loaded value: define DOWNCOUNTER_AUTORELOAD_EN.
//
// state | meaning
// IDLE  | waiting for a start value, count held at 0, load_ready high unless abort
// RUN   | counting down while enable is high, count always >= 1
// DONE  | expiry cycle, done high for exactly this cycle
module downcounter #(
  parameter int COUNT_BITS = 3
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  enable,
  input  logic                  abort,
  input  logic                  load_valid,
  input  logic [COUNT_BITS-1:0] load_value,
  output logic                  load_ready,
  output logic [COUNT_BITS-1:0] count,
  output logic                  busy,
  output logic                  done,
  output logic                  min_tick
);

  localparam logic [COUNT_BITS-1:0] CNT_ONE = COUNT_BITS'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [COUNT_BITS-1:0]   count_nxt;
  logic                    load_fire;

  assign load_ready = (state == ST_IDLE) && !abort;
  assign load_fire  = load_valid && load_ready;

`ifdef DOWNCOUNTER_AUTORELOAD_EN
  logic [COUNT_BITS-1:0] reload_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      reload_q <= '0;
    end else if (load_fire) begin
      reload_q <= load_value;
    end
  end
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
      count <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    if (abort) begin
      state_nxt = ST_IDLE;
      count_nxt = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          count_nxt = '0;
          if (load_fire) begin
            if (load_value != '0) begin
              state_nxt = ST_RUN;
              count_nxt = load_value;
            end else begin
              state_nxt = ST_DONE;
            end
          end
        end
        ST_RUN: begin
          if (enable) begin
            // RUN never holds 0; the <= guard keeps the counter from wrapping
            if (count <= CNT_ONE) begin
              state_nxt = ST_DONE;
              count_nxt = '0;
            end else begin
              count_nxt = count - CNT_ONE;
            end
          end
        end
        ST_DONE: begin
`ifdef DOWNCOUNTER_AUTORELOAD_EN
          if (reload_q != '0) begin
            state_nxt = ST_RUN;
            count_nxt = reload_q;
          end else begin
            state_nxt = ST_DONE;
            count_nxt = '0;
          end
`else
          state_nxt = ST_IDLE;
          count_nxt = '0;
`endif
        end
        default: begin
          state_nxt = ST_IDLE;
          count_nxt = '0;
        end
      endcase
    end
  end

  assign done     = (state == ST_DONE);
  assign busy     = (state != ST_IDLE);
  assign min_tick = (count == '0);

endmodule

// File: tb/tb_downcounter.sv
// Self-checking bench for downcounter: directed test-plan scenarios plus random traffic
// compared against a cycle-level behavioural model.
module tb_downcounter;

  localparam int CB = 3;

  logic          clk = 1'b0;
  logic          resetn;
  logic          enable;
  logic          abort;
  logic          load_valid;
  logic [CB-1:0] load_value;
  logic          load_ready;
  logic [CB-1:0] count;
  logic          busy;
  logic          done;
  logic          min_tick;

  int n_checks = 0;
  int n_errors = 0;

  // reference model: remaining count, whether a timer is active, whether it is expiring
  int m_count;
  int m_reload;
  bit m_busy;
  bit m_done;

  downcounter #(.COUNT_BITS(CB)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .enable     (enable),
    .abort      (abort),
    .load_valid (load_valid),
    .load_value (load_value),
    .load_ready (load_ready),
    .count      (count),
    .busy       (busy),
    .done       (done),
    .min_tick   (min_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_count  = 0;
    m_reload = 0;
    m_busy   = 0;
    m_done   = 0;
  endtask

  // applies the behavioural rules for one rising edge using the current inputs
  task automatic model_edge();
    if (abort) begin
      m_count = 0;
      m_busy  = 0;
      m_done  = 0;
    end else if (!m_busy) begin
      if (load_valid) begin
        m_reload = int'(load_value);
        m_busy   = 1;
        m_count  = int'(load_value);
        m_done   = (load_value == 0);
      end
    end else if (m_done) begin
`ifdef DOWNCOUNTER_AUTORELOAD_EN
      if (m_reload != 0) begin
        m_done  = 0;
        m_count = m_reload;
      end
`else
      m_done = 0;
      m_busy = 0;
`endif
    end else if (enable) begin
      m_count = m_count - 1;
      if (m_count == 0) m_done = 1;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".count"}, 32'(count), 32'(m_count));
    chk({tag, ".busy"}, 32'(busy), 32'(m_busy));
    chk({tag, ".done"}, 32'(done), 32'(m_done));
    chk({tag, ".min_tick"}, 32'(min_tick), 32'(m_count == 0));
  endtask

  task automatic drive(input bit en, input bit ab, input bit lv, input int val);
    enable     = en;
    abort      = ab;
    load_valid = lv;
    load_value = CB'(val);
  endtask

  // one clock: check combinational ready, advance DUT and model, check registered outputs
  task automatic step(input string tag);
    #1;
    chk({tag, ".load_ready"}, 32'(load_ready), 32'(!m_busy && !abort));
    @(posedge clk);
    model_edge();
    #1;
    check_model(tag);
  endtask

  initial begin
    int cyc;
    int done_cyc;
    int done_cnt;

    resetn = 1'b0;
    drive(0, 0, 0, 0);
    model_reset();
    #12;
    chk("reset.count", 32'(count), 0);
    chk("reset.busy", 32'(busy), 0);
    chk("reset.done", 32'(done), 0);
    chk("reset.load_ready", 32'(load_ready), 1);
    chk("reset.min_tick", 32'(min_tick), 1);
    resetn = 1'b1;

`ifndef DOWNCOUNTER_AUTORELOAD_EN
    // basic countdown of 5
    drive(1, 0, 1, 5);
    step("basic_hs");
    drive(1, 0, 0, 2);
    for (int k = 0; k < 6; k++) begin
      chk("basic.count_seq", 32'(count), 32'(5 - k));
      chk("basic.done_seq", 32'(done), 32'(k == 5));
      step("basic");
    end
    chk("basic.busy_fall", 32'(busy), 0);

    // zero load
    drive(1, 0, 1, 0);
    step("zero_hs");
    chk("zero.done_first", 32'(done), 1);
    chk("zero.min_tick", 32'(min_tick), 1);
    drive(1, 0, 0, 6);
    step("zero");
    chk("zero.done_once", 32'(done), 0);

    // pause at count 4 for 3 cycles
    drive(1, 0, 1, 7);
    step("pause_hs");
    drive(1, 0, 0, 0);
    cyc      = 1;
    done_cyc = -1;
    while (cyc <= 13) begin
      if (done && done_cyc < 0) done_cyc = cyc;
      if (count == 4 && enable && cyc == 4) begin
        drive(0, 0, 0, 0);
        for (int p = 0; p < 3; p++) begin
          step("pause_hold");
          chk("pause.count_hold", 32'(count), 4);
          cyc++;
        end
        drive(1, 0, 0, 0);
      end else begin
        step("pause");
        cyc++;
      end
    end
    chk("pause.done_cycle", 32'(done_cyc), 11);
`endif

    // abort together with a load offer in IDLE
    drive(1, 1, 1, 5);
    #1;
    chk("abort_idle.load_ready", 32'(load_ready), 0);
    step("abort_idle");
    chk("abort_idle.count", 32'(count), 0);
    chk("abort_idle.busy", 32'(busy), 0);

    // abort in RUN at count 3
    drive(1, 0, 1, 5);
    step("abort_run_hs");
    drive(1, 0, 0, 0);
    step("abort_run");
    step("abort_run");
    chk("abort_run.at3", 32'(count), 3);
    drive(1, 1, 0, 0);
    step("abort_run_hit");
    chk("abort_run.idle", 32'(busy), 0);
    chk("abort_run.count0", 32'(count), 0);
    drive(1, 0, 0, 0);
    done_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      step("abort_run_after");
      if (done) done_cnt++;
    end
    chk("abort_run.no_done", 32'(done_cnt), 0);

    // asynchronous reset mid-count
    drive(1, 0, 1, 7);
    step("areset_hs");
    drive(1, 0, 0, 0);
    step("areset");
    chk("areset.at6", 32'(count), 6);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("areset.count", 32'(count), 0);
    chk("areset.busy", 32'(busy), 0);
    chk("areset.done", 32'(done), 0);
    model_reset();
    #1;
    resetn = 1'b1;

`ifdef DOWNCOUNTER_AUTORELOAD_EN
    // auto-reload period 2: done every 3 cycles
    drive(1, 0, 1, 2);
    step("ar_hs");
    drive(1, 0, 0, 0);
    done_cnt = 0;
    for (int k = 1; k <= 12; k++) begin
      chk("ar.load_ready", 32'(load_ready), 0);
      chk("ar.done_phase", 32'(done), 32'(k % 3 == 0));
      if (done) done_cnt++;
      step("ar");
    end
    chk("ar.periods", 32'(done_cnt), 4);
    drive(1, 1, 0, 0);
    step("ar_abort");
    drive(1, 0, 0, 0);
    #1;
    chk("ar.ready_back", 32'(load_ready), 1);
`endif

    // random traffic against the model
    for (int k = 0; k < 600; k++) begin
      drive($urandom_range(0, 9) < 8, $urandom_range(0, 29) == 0,
            $urandom_range(0, 2) == 0, int'($urandom_range(0, (1 << CB) - 1)));
      step("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
